// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (core load/store) and port 1
// (loader/debug) share one single-cycle data memory. Grants are registered
// and last one cycle. A port is never granted on consecutive cycles, and a
// tie between the ports is broken round-robin.
module dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          stall0,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  // Each grant owns one state bit, so a grant output is a flop output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_P0   = 2'b01,
    ST_P1   = 2'b10
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic          last_q;
  logic          last_d;
  logic          elig0;
  logic          elig1;

  logic          rvalid0_q;
  logic          rvalid0_d;
  logic          rvalid1_q;
  logic          rvalid1_d;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata0_d;
  logic [DW-1:0] rdata1_q;
  logic [DW-1:0] rdata1_d;

  // Grant state and round-robin pointer; after reset port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Pick the next grant; the port granted this cycle sits out the next one.
  always_comb begin
    state_d = ST_IDLE;
    last_d  = last_q;
    elig0   = req0 & (state_q != ST_P0);
    elig1   = req1 & (state_q != ST_P1);
    if (elig0 && elig1) begin
      state_d = last_q ? ST_P0 : ST_P1;
    end else if (elig0) begin
      state_d = ST_P0;
    end else if (elig1) begin
      state_d = ST_P1;
    end
    if (state_d == ST_P0) begin
      last_d = 1'b0;
    end else if (state_d == ST_P1) begin
      last_d = 1'b1;
    end
  end

  // Decode grants, core stall and the memory-side mux from the grant state.
  always_comb begin
    gnt0   = state_q[0];
    gnt1   = state_q[1];
    stall0 = req0 & ~state_q[0];
    mem_a  = addr0;
    mem_wd = wdata0;
    if (state_q[1]) begin
      mem_a  = addr1;
      mem_wd = wdata1;
    end
    mem_we = ~rst & ((state_q[0] & we0) | (state_q[1] & we1));
  end

  // Read return: capture memory data only at the end of a read grant cycle.
  always_comb begin
    rvalid0_d = state_q[0] & ~we0;
    rvalid1_d = state_q[1] & ~we1;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (rvalid0_d) begin
      rdata0_d = mem_rd;
    end
    if (rvalid1_d) begin
      rdata1_d = mem_rd;
    end
  end

  // Read return registers; a reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Registered read-return outputs.
  always_comb begin
    rvalid0 = rvalid0_q;
    rvalid1 = rvalid1_q;
    rdata0  = rdata0_q;
    rdata1  = rdata1_q;
  end

endmodule
